// File: rtl/shift_unit_scheduler_pkg.sv
// Shared definitions for the shift unit scheduler: default sizes, op codes
// and the scheduler FSM state encoding.
package shift_unit_scheduler_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_NSTAGE = 5;

  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_ROTR = 2'b10,
    OP_SLL  = 2'b11
  } shiftOp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_unit_scheduler_stage.sv
// One fixed-distance shift stage covering all four ops; purely combinational.
// A full shift is the composition of power-of-two stages.
module shift_stage
  import shift_unit_scheduler_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DISTANCE = 1
) (
  input  logic [WIDTH-1:0] din,
  input  shiftOp_e         op,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (op)
      OP_SRL:  dout = {{DISTANCE{1'b0}}, din[WIDTH-1:DISTANCE]};
      OP_SRA:  dout = {{DISTANCE{din[WIDTH-1]}}, din[WIDTH-1:DISTANCE]};
      OP_ROTR: dout = {din[DISTANCE-1:0], din[WIDTH-1:DISTANCE]};
      OP_SLL:  dout = {din[WIDTH-DISTANCE-1:0], {DISTANCE{1'b0}}};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_unit_scheduler.sv
// Two-requester round-robin front end for an iterative barrel shifter that
// applies one power-of-two stage per cycle, then holds the result until taken.
module shift_unit_scheduler
  import shift_unit_scheduler_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NSTAGE = DEFAULT_NSTAGE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_data,
  input  logic [NSTAGE-1:0] req0_amt,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_data,
  input  logic [NSTAGE-1:0] req1_amt,
  input  logic [1:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_id,
  output logic              busy
);

  localparam int IDXW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  state_e            stateReg, stateNext;
  logic [WIDTH-1:0]  workReg, workNext;
  logic [NSTAGE-1:0] amtReg, amtNext;
  shiftOp_e          opReg, opNext;
  logic              idReg, idNext;
  logic [IDXW-1:0]   stageReg, stageNext;
  // prioReg set means requester 1 wins the next tie
  logic              prioReg, prioNext;

  logic              grant0, grant1, isIdle;
  logic [WIDTH-1:0]  stageOut [NSTAGE];

  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : gStage
      shift_stage #(
        .WIDTH    (WIDTH),
        .DISTANCE (1 << gi)
      ) uStage (
        .din  (workReg),
        .op   (opReg),
        .dout (stageOut[gi])
      );
    end
  endgenerate

  assign grant0 = req0_valid & (~req1_valid | ~prioReg);
  assign grant1 = req1_valid & ~grant0;
  assign isIdle = (stateReg == ST_IDLE);

  // Readies stay low while reset is held so no handshake appears to complete.
  assign req0_ready = isIdle & ~reset & grant0;
  assign req1_ready = isIdle & ~reset & grant1;

  assign busy      = ~isIdle;
  assign rsp_valid = (stateReg == ST_RESP);
  assign rsp_data  = rsp_valid ? workReg : '0;
  assign rsp_id    = rsp_valid ? idReg : 1'b0;

  always_comb begin
    stateNext = stateReg;
    workNext  = workReg;
    amtNext   = amtReg;
    opNext    = opReg;
    idNext    = idReg;
    stageNext = stageReg;
    prioNext  = prioReg;
    case (stateReg)
      ST_IDLE: begin
        if (grant0 | grant1) begin
          workNext  = grant1 ? req1_data : req0_data;
          amtNext   = grant1 ? req1_amt : req0_amt;
          opNext    = shiftOp_e'(grant1 ? req1_op : req0_op);
          idNext    = grant1;
          prioNext  = grant0;
          stageNext = IDXW'(NSTAGE - 1);
          stateNext = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (amtReg[stageReg]) begin
          workNext = stageOut[stageReg];
        end
        if (stageReg == '0) begin
          stateNext = ST_RESP;
        end else begin
          stageNext = stageReg - IDXW'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg <= ST_IDLE;
      workReg  <= '0;
      amtReg   <= '0;
      opReg    <= OP_SRL;
      idReg    <= 1'b0;
      stageReg <= '0;
      prioReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      workReg  <= workNext;
      amtReg   <= amtNext;
      opReg    <= opNext;
      idReg    <= idNext;
      stageReg <= stageNext;
      prioReg  <= prioNext;
    end
  end

endmodule
